// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the per-output wormhole switch allocator.
//   CN          : number of router ports (outputs of the allocator)
//   PORT_*      : bit position of each port in request / grant rows
//   sa_state_e  : per-output allocator state
package switch_allocator_pkg;

    localparam int unsigned CN = 6;

    localparam int unsigned PORT_N = 0;
    localparam int unsigned PORT_W = 1;
    localparam int unsigned PORT_S = 2;
    localparam int unsigned PORT_E = 3;
    localparam int unsigned PORT_L = 4;
    localparam int unsigned PORT_B = 5;

    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr_i, searching cyclically (N-1 wraps to 0).
//   req_i   : request vector, one bit per input
//   ptr_i   : highest-priority index for this round
//   gnt_o   : one-hot winner (zero when no request)
//   idx_o   : index of the winner (zero when no request)
//   valid_o : at least one request was present
module rr_arbiter #(
    parameter int unsigned N  = 6,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Walk N positions starting at the pointer; first hit wins.
    always_comb begin
        int unsigned j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator. Each output independently locks to
// one input from head to tail flit, chosen round-robin among inputs that
// present a clean one-hot request and currently own no other output.
//   clk           : clock
//   rstn          : asynchronous active-low reset
//   req           : per-input one-hot requested output, row i at [i*NUM_OUT +: NUM_OUT]
//   flit_fire     : input i moved a flit through the crossbar this cycle
//   tail          : the flit fired by input i is a tail
//   out_credit_ok : output o has downstream space (gates allocation only)
//   grant         : registered, grant[i*NUM_OUT+o] = input i owns output o
//   out_busy      : registered, output o is locked
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned NUM_IN  = 6,
    parameter int unsigned NUM_OUT = CN
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_IN*NUM_OUT-1:0]   req,
    input  logic [NUM_IN-1:0]           flit_fire,
    input  logic [NUM_IN-1:0]           tail,
    input  logic [NUM_OUT-1:0]          out_credit_ok,
    output logic [NUM_IN*NUM_OUT-1:0]   grant,
    output logic [NUM_OUT-1:0]          out_busy
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned GW    = NUM_IN * NUM_OUT;

    sa_state_e          state_q [NUM_OUT];
    sa_state_e          state_d [NUM_OUT];
    logic [IDX_W-1:0]   ptr_q   [NUM_OUT];
    logic [IDX_W-1:0]   ptr_d   [NUM_OUT];
    logic [IDX_W-1:0]   owner_q [NUM_OUT];
    logic [IDX_W-1:0]   owner_d [NUM_OUT];
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      grant_d;
    logic [NUM_OUT-1:0] busy_q;
    logic [NUM_OUT-1:0] busy_d;

    logic [NUM_IN-1:0]  row_onehot;
    logic [NUM_IN-1:0]  in_owns;
    logic [NUM_IN-1:0]  col_req [NUM_OUT];
    logic [NUM_IN-1:0]  win_oh  [NUM_OUT];
    logic [IDX_W-1:0]   win_idx [NUM_OUT];
    logic [NUM_OUT-1:0] win_vld;

    // Row qualification: multi-hot rows are treated as no request, and an
    // input that already holds an output may not start a second packet.
    always_comb begin
        logic [NUM_OUT-1:0] row;
        row        = '0;
        row_onehot = '0;
        in_owns    = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            row           = req[i*NUM_OUT +: NUM_OUT];
            row_onehot[i] = (row != '0) && ((row & (row - NUM_OUT'(1))) == '0);
            in_owns[i]    = |grant_q[i*NUM_OUT +: NUM_OUT];
        end
    end

    // One arbiter per output over the column of valid requests.
    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        for (genvar i = 0; i < NUM_IN; i++) begin : g_col
            assign col_req[o][i] = row_onehot[i] & ~in_owns[i] & req[i*NUM_OUT + o];
        end

        rr_arbiter #(
            .N  (NUM_IN),
            .IW (IDX_W)
        ) u_rr_arbiter (
            .req_i   (col_req[o]),
            .ptr_i   (ptr_q[o]),
            .gnt_o   (win_oh[o]),
            .idx_o   (win_idx[o]),
            .valid_o (win_vld[o])
        );
    end

    // Per-output lock / release next-state logic.
    always_comb begin
        grant_d = grant_q;
        busy_d  = '0;
        for (int unsigned o = 0; o < NUM_OUT; o++) begin
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            owner_d[o] = owner_q[o];
            if (state_q[o] == SA_IDLE) begin
                // Credit gates only the head allocation, never a held lock.
                if (win_vld[o] && out_credit_ok[o]) begin
                    state_d[o] = SA_LOCKED;
                    owner_d[o] = win_idx[o];
                    ptr_d[o]   = (win_idx[o] == IDX_W'(NUM_IN - 1)) ? '0
                                                                     : win_idx[o] + IDX_W'(1);
                    for (int unsigned i = 0; i < NUM_IN; i++) begin
                        grant_d[i*NUM_OUT + o] = win_oh[o][i];
                    end
                end
            end else begin
                // Only the owner's tail fire releases; others are ignored.
                if (flit_fire[owner_q[o]] && tail[owner_q[o]]) begin
                    state_d[o] = SA_IDLE;
                    for (int unsigned i = 0; i < NUM_IN; i++) begin
                        grant_d[i*NUM_OUT + o] = 1'b0;
                    end
                end
            end
            busy_d[o] = (state_d[o] == SA_LOCKED);
        end
    end

    // State, pointer, owner and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= SA_IDLE;
                ptr_q[o]   <= '0;
                owner_q[o] <= '0;
            end
            grant_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                owner_q[o] <= owner_d[o];
            end
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign out_busy = busy_q;

endmodule
